// File: rtl/screen_painter.sv
// Full-frame raster copy from a screen memory to the VGA adapter.
// Coordinates ride a RD_LAT-deep pipeline so they line up with the read data.
module screen_painter #(
   parameter int WIDTH    = 160,
   parameter int HEIGHT   = 120,
   parameter int ADDR_W   = 15,
   parameter int COLOUR_W = 3,
   parameter int RD_LAT   = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mem_ready,
   input  logic                start,
   input  logic [1:0]          screen_sel,
   input  logic [31:0]         q1,
   input  logic [31:0]         q2,
   input  logic [31:0]         qs,
   output logic [ADDR_W-1:0]   rdaddress,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
   localparam int                DW     = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          xc_q;
   logic [6:0]          yc_q;
   logic [1:0]          sel_q;
   logic [DW-1:0]       drain_q;
   logic                busy_q;
   logic                done_q;

   logic [RD_LAT-1:0]       pv_q;
   logic [RD_LAT-1:0][7:0]  px_q;
   logic [RD_LAT-1:0][6:0]  py_q;

   logic [COLOUR_W-1:0] col_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         xc_q    <= '0;
         yc_q    <= '0;
         sel_q   <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && mem_ready) begin
                  sel_q   <= screen_sel;
                  addr_q  <= '0;
                  xc_q    <= '0;
                  yc_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (addr_q == LAST_A) begin
                  drain_q <= '0;
                  state_q <= DRAIN;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                  if (xc_q == X_LAST) begin
                     xc_q <= '0;
                     yc_q <= yc_q + 7'd1;
                  end else begin
                     xc_q <= xc_q + 8'd1;
                  end
               end
            end
            DRAIN: begin
               // last address needs RD_LAT cycles to reach the plot output
               if (drain_q == DW'(RD_LAT - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pv_q <= '0;
         px_q <= '0;
         py_q <= '0;
      end else begin
         pv_q[0] <= (state_q == SCAN);
         px_q[0] <= xc_q;
         py_q[0] <= yc_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
         end
      end
   end

   // colour is taken straight from q so it aligns with the delayed x/y
   always_comb begin
      col_d = '0;
      unique case (sel_q)
         2'd0: col_d = q1[COLOUR_W-1:0];
         2'd1: col_d = q2[COLOUR_W-1:0];
         2'd2: col_d = qs[COLOUR_W-1:0];
         default: col_d = '0;
      endcase
      if (!pv_q[RD_LAT-1]) col_d = '0;
   end

   logic unused_q_bits;
   assign unused_q_bits = ^{q1[31:COLOUR_W], q2[31:COLOUR_W], qs[31:COLOUR_W]};

   assign rdaddress = addr_q;
   assign x         = px_q[RD_LAT-1];
   assign y         = py_q[RD_LAT-1];
   assign plot      = pv_q[RD_LAT-1];
   assign colour    = col_d;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
